// File: rtl/fx_fir_pkg.sv
// Shared definitions for the time-multiplexed fixed-point FIR.
// Holds default widths, the FSM state encoding and the sign-magnitude helpers
// used by the MAC engine and the output normaliser.
package fx_fir_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned COEF_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    NORM = 2'd2,
    OUT  = 2'd3
  } fir_state_e;

  // Sign-magnitude value of 'width' bits (sign at width-1) to two's complement.
  function automatic logic signed [63:0] sm_to_tc(input logic [63:0] value,
                                                  input int unsigned width);
    logic [63:0] mag;
    mag = value & ((64'd1 << (width - 1)) - 64'd1);
    if (value[6'(width - 1)]) begin
      return -$signed(mag);
    end
    return $signed(mag);
  endfunction

  // Two's complement to sign-magnitude: |acc| >> shift, saturated to the
  // 'width'-bit magnitude range; a zero magnitude never carries a sign.
  function automatic logic [63:0] tc_to_sm_sat(input logic signed [63:0] acc,
                                               input int unsigned shift,
                                               input int unsigned width);
    logic [63:0] mag;
    logic [63:0] max_mag;
    logic        neg;
    neg     = acc[63];
    mag     = neg ? 64'(-acc) : 64'(acc);
    mag     = mag >> shift;
    max_mag = (64'd1 << (width - 1)) - 64'd1;
    if (mag > max_mag) begin
      mag = max_mag;
    end
    if (mag == 64'd0) begin
      return 64'd0;
    end
    return mag | (64'(neg) << (width - 1));
  endfunction

endpackage

// File: rtl/fx_fir_tdm_if.sv
// Sample stream and coefficient-write bus of fx_fir_tdm.
// master: the side that feeds samples, consumes results and writes coefficients.
// slave : the filter itself.
interface fx_fir_tdm_if
  import fx_fir_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned COEF_W = COEF_W_DEF,
  parameter int unsigned TAPS   = 30,
  parameter int unsigned BANKS  = 4
) ();

  localparam int unsigned BAND_W = $clog2(BANKS);
  localparam int unsigned ADDR_W = $clog2(TAPS);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [BAND_W-1:0] band_sel;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              coef_we;
  logic [BAND_W-1:0] coef_bank;
  logic [ADDR_W-1:0] coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic              coef_err;

  modport master (
    output in_valid, in_data, band_sel, out_ready,
    output coef_we, coef_bank, coef_addr, coef_data,
    input  in_ready, out_valid, out_data, coef_err
  );

  modport slave (
    input  in_valid, in_data, band_sel, out_ready,
    input  coef_we, coef_bank, coef_addr, coef_data,
    output in_ready, out_valid, out_data, coef_err
  );

endinterface

// File: rtl/fx_sm_mac.sv
// Sign-magnitude multiply-accumulate engine.
// Ports: clk/rst (sync, active-low), clr zeroes the accumulator, en adds x*c,
// x/c sign-magnitude operands, acc two's-complement running sum.
module fx_sm_mac
  import fx_fir_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned COEF_W = COEF_W_DEF,
  parameter int unsigned ACC_W  = 36
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] x,
  input  logic [COEF_W-1:0] c,
  output logic [ACC_W-1:0]  acc
);

  localparam int unsigned PROD_W = DATA_W + COEF_W - 2;

  logic              prod_sign;
  logic [PROD_W-1:0] prod_mag;
  logic [ACC_W-1:0]  prod_tc;

  // Product in sign-magnitude, then widened to the accumulator's two's complement.
  always_comb begin
    prod_sign = x[DATA_W-1] ^ c[COEF_W-1];
    prod_mag  = PROD_W'(x[DATA_W-2:0]) * PROD_W'(c[COEF_W-2:0]);
    prod_tc   = ACC_W'(sm_to_tc(64'({prod_sign, prod_mag}), PROD_W + 1));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_tc;
    end
  end

endmodule

// File: rtl/fx_fir_tdm.sv
// Time-multiplexed multi-bank FIR: one MAC evaluates TAPS products per sample.
// Ports: clk_slow, rst (sync, active-low), bus (sample in/out handshakes and
// coefficient writes, slave side), busy (high while MAC or NORM).
module fx_fir_tdm
  import fx_fir_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned COEF_W = COEF_W_DEF,
  parameter int unsigned TAPS   = 30,
  parameter int unsigned BANKS  = 4,
  parameter int unsigned ACC_W  = DATA_W + COEF_W + $clog2(TAPS) - 1
) (
  input  logic        clk_slow,
  input  logic        rst,
  fx_fir_tdm_if.slave bus,
  output logic        busy
);

  localparam int unsigned BAND_W = $clog2(BANKS);
  localparam int unsigned ADDR_W = $clog2(TAPS);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_MAC  = MAC;
  localparam logic [1:0] ST_NORM = NORM;
  localparam logic [1:0] ST_OUT  = OUT;

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [ADDR_W-1:0] k_q;
  logic [BAND_W-1:0] band_q;
  logic [DATA_W-1:0] dline_q [TAPS];
  logic [COEF_W-1:0] coef_q  [BANKS][TAPS];
  logic [ACC_W-1:0]  acc;

  logic accept_c;
  logic mac_en_c;
  logic last_tap_c;
  logic coef_ok_c;
  logic in_ready_d;
  logic out_valid_d;
  logic busy_d;

  // Next state, strobes and next values of the registered status outputs.
  always_comb begin
    state_d    = state_q;
    accept_c   = 1'b0;
    mac_en_c   = 1'b0;
    last_tap_c = (32'(k_q) == TAPS - 1);
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && bus.in_ready) begin
          accept_c = 1'b1;
          state_d  = ST_MAC;
        end
      end
      ST_MAC: begin
        mac_en_c = 1'b1;
        if (last_tap_c) begin
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_OUT);
    busy_d      = (state_d == ST_MAC) || (state_d == ST_NORM);
    // Coefficients may only change while no sample is being computed.
    coef_ok_c   = ((state_q == ST_IDLE) || (state_q == ST_OUT)) &&
                  (32'(bus.coef_addr) < TAPS) && (32'(bus.coef_bank) < BANKS);
  end

  // State register and registered status outputs.
  always_ff @(posedge clk_slow) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      bus.in_ready  <= in_ready_d;
      bus.out_valid <= out_valid_d;
      busy          <= busy_d;
    end
  end

  // Tap counter: walks k = 0..TAPS-1 during MAC.
  always_ff @(posedge clk_slow) begin
    if (!rst) begin
      k_q <= '0;
    end else if (accept_c) begin
      k_q <= '0;
    end else if (mac_en_c) begin
      k_q <= last_tap_c ? '0 : k_q + ADDR_W'(1);
    end
  end

  // Delay line (index 0 = newest sample) and per-sample bank latch.
  always_ff @(posedge clk_slow) begin
    if (!rst) begin
      band_q <= '0;
      for (int i = 0; i < int'(TAPS); i++) begin
        dline_q[i] <= '0;
      end
    end else if (accept_c) begin
      band_q     <= bus.band_sel;
      dline_q[0] <= bus.in_data;
      for (int i = 1; i < int'(TAPS); i++) begin
        dline_q[i] <= dline_q[i-1];
      end
    end
  end

  // Coefficient register file and rejected-write flag.
  always_ff @(posedge clk_slow) begin
    if (!rst) begin
      bus.coef_err <= 1'b0;
      for (int b = 0; b < int'(BANKS); b++) begin
        for (int t = 0; t < int'(TAPS); t++) begin
          coef_q[b][t] <= '0;
        end
      end
    end else begin
      bus.coef_err <= bus.coef_we && !coef_ok_c;
      if (bus.coef_we && coef_ok_c) begin
        coef_q[bus.coef_bank][bus.coef_addr] <= bus.coef_data;
      end
    end
  end

  // Output sample: normalised and saturated once, then held through OUT.
  always_ff @(posedge clk_slow) begin
    if (!rst) begin
      bus.out_data <= '0;
    end else if (state_q == ST_NORM) begin
      bus.out_data <= DATA_W'(tc_to_sm_sat(64'($signed(acc)), COEF_W - 1, DATA_W));
    end
  end

  fx_sm_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk (clk_slow),
    .rst (rst),
    .clr (accept_c),
    .en  (mac_en_c),
    .x   (dline_q[k_q]),
    .c   (coef_q[band_q][k_q]),
    .acc (acc)
  );

endmodule

// File: tb/tb_fx_fir_tdm.sv
module tb_fx_fir_tdm;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int TAPS   = 30;
  localparam int BANKS  = 4;

  logic clk_slow = 1'b0;
  logic rst;
  logic busy;

  always #5 clk_slow = ~clk_slow;

  fx_fir_tdm_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .BANKS(BANKS)) bus ();

  fx_fir_tdm #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .BANKS(BANKS)) dut (
    .clk_slow (clk_slow),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int          lat      = 0;
  int          hist  [TAPS];
  int          coefm [BANKS][TAPS];
  logic [15:0] exp_out;

  task automatic tick();
    @(posedge clk_slow);
    #1;
    lat++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: signed integers, direct convolution sum, then scaling.
  function automatic int sm2i(input logic [15:0] v);
    int m;
    m = int'(v[14:0]);
    return v[15] ? -m : m;
  endfunction

  function automatic logic [15:0] ref_out(input int band);
    longint s;
    longint mag;
    s = 0;
    for (int k = 0; k < TAPS; k++) begin
      s += longint'(coefm[band][k]) * longint'(hist[k]);
    end
    mag = (s < 0) ? -s : s;
    mag = mag / 32768;
    if (mag > 32767) mag = 32767;
    if (mag == 0) return 16'h0000;
    return {(s < 0), 15'(mag)};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin
      hist[k] = 0;
      for (int b = 0; b < BANKS; b++) coefm[b][k] = 0;
    end
  endtask

  task automatic model_accept(input logic [15:0] d, input int band);
    for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = sm2i(d);
    exp_out = ref_out(band);
  endtask

  task automatic coef_wr(input int bank, input int addr, input logic [15:0] data,
                         input bit busy_now);
    bit exp_err;
    exp_err       = busy_now || (addr >= TAPS);
    bus.coef_we   = 1'b1;
    bus.coef_bank = 2'(bank);
    bus.coef_addr = 5'(addr);
    bus.coef_data = data;
    tick();
    bus.coef_we   = 1'b0;
    chk("coef_err", 32'(bus.coef_err), 32'(exp_err));
    if (!exp_err) coefm[bank][addr] = sm2i(data);
  endtask

  task automatic start_sample(input logic [15:0] d, input int band);
    int guard;
    guard        = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.band_sel = 2'(band);
    while (bus.in_ready !== 1'b1 && guard < 200) begin
      tick();
      guard++;
    end
    chk("accept_wait", 32'(guard < 200), 32'h1);
    tick();
    lat          = 1;
    bus.in_valid = 1'b0;
    bus.in_data  = 16'($urandom);
    bus.band_sel = 2'($urandom);
    model_accept(d, band);
    chk("busy_after_accept", 32'(busy), 32'h1);
    chk("in_ready_after_accept", 32'(bus.in_ready), 32'h0);
  endtask

  task automatic wait_out(input string tag);
    while (bus.out_valid !== 1'b1 && lat < 100) tick();
    chk("latency", 32'(lat), 32'd32);
    chk(tag, 32'(bus.out_data), 32'(exp_out));
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("out_valid_drop", 32'(bus.out_valid), 32'h0);
    chk("in_ready_back", 32'(bus.in_ready), 32'h1);
  endtask

  task automatic run_sample(input logic [15:0] d, input int band, input int hold,
                            input string tag);
    start_sample(d, band);
    wait_out(tag);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_data", 32'(bus.out_data), 32'(exp_out));
      chk("hold_in_ready", 32'(bus.in_ready), 32'h0);
    end
    consume();
  endtask

  initial begin
    logic [15:0] d;
    bit          seen;

    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.band_sel  = '0;
    bus.out_ready = 1'b0;
    bus.coef_we   = 1'b0;
    bus.coef_bank = '0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    model_reset();

    // Reset state
    repeat (3) tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data", 32'(bus.out_data), 32'h0);
    chk("rst_coef_err", 32'(bus.coef_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'h1);

    // Impulse through bank 0 tap 3
    coef_wr(0, 3, 16'h0040, 1'b0);
    for (int n = 0; n < 10; n++) begin
      run_sample((n == 0) ? 16'h7FFF : 16'h0000, 0, 0, "impulse");
      if (n == 3) chk("impulse_peak", 32'(bus.out_data), 32'h003F);
    end

    // Rejected writes: during MAC and with an out-of-range tap index
    start_sample(16'h0000, 0);
    coef_wr(0, 3, 16'h1234, 1'b1);
    tick();
    chk("coef_err_one_cycle", 32'(bus.coef_err), 32'h0);
    wait_out("busy_write_sample");
    consume();
    coef_wr(1, 30, 16'h7FFF, 1'b0);
    for (int n = 0; n < 5; n++) begin
      run_sample((n == 0) ? 16'h7FFF : 16'h0000, 0, 0, "impulse_readback");
      if (n == 3) chk("readback_peak", 32'(bus.out_data), 32'h003F);
    end

    // Band switch, alternating per sample
    coef_wr(2, 0, 16'h4000, 1'b0);
    coef_wr(3, 0, 16'hC000, 1'b0);
    for (int n = 0; n < 4; n++) begin
      run_sample(16'h2000, 2 + (n % 2), 0, "band_switch");
      chk("band_const", 32'(bus.out_data), (n % 2 == 0) ? 32'h1000 : 32'h9000);
    end

    // Saturation, both signs
    for (int k = 0; k < TAPS; k++) coef_wr(1, k, 16'h7FFF, 1'b0);
    for (int n = 0; n < 31; n++) run_sample(16'h7FFF, 1, 0, "sat_pos");
    chk("sat_pos_final", 32'(bus.out_data), 32'h7FFF);
    for (int n = 0; n < 31; n++) run_sample(16'hFFFF, 1, 0, "sat_neg");
    chk("sat_neg_final", 32'(bus.out_data), 32'hFFFF);

    // Backpressure with a held in_valid, plus a write accepted during OUT
    start_sample(16'h7FFF, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h1111;
    wait_out("bp_data");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_data", 32'(bus.out_data), 32'(exp_out));
      chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'h1);
    end
    coef_wr(0, 5, 16'h0100, 1'b0);
    chk("bp_after_write", 32'(bus.out_data), 32'(exp_out));
    consume();
    bus.in_valid = 1'b0;
    for (int n = 0; n < 3; n++) run_sample(16'h0000, 0, 0, "after_bp");

    // Randomized coefficients and samples
    for (int i = 0; i < 12; i++) begin
      coef_wr($urandom_range(0, 3), $urandom_range(0, 31), 16'($urandom), 1'b0);
    end
    for (int n = 0; n < 16; n++) begin
      d = 16'($urandom);
      if (n % 4 == 0) d = d & 16'h80FF;
      run_sample(d, $urandom_range(0, 3), $urandom_range(0, 2), "random");
    end

    // Reset mid-MAC aborts the sample and clears all state
    start_sample(16'h7FFF, 1);
    repeat (5) tick();
    rst = 1'b0;
    tick();
    chk("abort_rst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("abort_rst_busy", 32'(busy), 32'h0);
    rst = 1'b1;
    tick();
    chk("abort_in_ready", 32'(bus.in_ready), 32'h1);
    model_reset();
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    chk("abort_no_output", 32'(seen), 32'h0);
    for (int k = 0; k < TAPS; k++) coef_wr(0, k, 16'h4000, 1'b0);
    for (int n = 0; n < 3; n++) begin
      run_sample(16'h0000, 0, 0, "fresh_history");
      chk("fresh_zero", 32'(bus.out_data), 32'h0);
    end
    run_sample(16'h7FFF, 0, 0, "fresh_impulse");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
